// File: rtl/ps2_kbd_pkg.sv
// Shared constants, receiver state encoding and frame-check helper for the PS/2 keyboard port.
// PS2_PARITY_CHECK_EN (optional define) enables rejection of frames with bad parity or stop bit.
package ps2_kbd_pkg;

  localparam logic [7:0] DATA_PORT_DEF   = 8'h0A;
  localparam logic [7:0] STATUS_PORT_DEF = 8'h0B;
  localparam int         FILTER_LEN_DEF  = 8;
  localparam logic [7:0] BREAK_CODE      = 8'hF0;
  localparam logic [7:0] EXT_CODE        = 8'hE0;
  localparam logic [3:0] FRAME_BITS      = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  // Frame bits [8:0] are data+parity (must be odd), bit [9] is the stop bit.
  function automatic logic frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) & frame[9];
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronises ps2c/ps2d, deglitches the clock and shifts in frames on falling edges.
// With PS2_PARITY_CHECK_EN defined, frames failing parity or stop-bit checks are dropped.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_done,
  output logic [7:0] rx_byte
);

  logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_tick;
  rx_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [9:0]            sreg_q, sreg_d;
  logic                  rx_done_q, rx_done_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  frame_accept;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_accept = frame_ok(sreg_q);
`else
  logic frame_unused;
  assign frame_accept = 1'b1;
  assign frame_unused = ^sreg_q[9:8];
`endif

  // Filtered clock only changes after FILTER_LEN agreeing samples.
  always_comb begin
    filt_d = {c_sync_q, filt_q[FILTER_LEN-1:1]};
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end else begin
      fclk_d = fclk_q;
    end
    fall_tick = fclk_q & ~fclk_d;
  end

  // Frame FSM; a high data line on a falling edge in IDLE is not a start bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    rx_done_d = 1'b0;
    rx_byte_d = rx_byte_q;
    case (state_q)
      IDLE: begin
        if (fall_tick && !d_sync_q) begin
          cnt_d   = FRAME_BITS;
          state_d = RX;
        end else begin
          state_d = IDLE;
        end
      end
      RX: begin
        if (fall_tick) begin
          sreg_d = {d_sync_q, sreg_q[9:1]};
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
          end else begin
            state_d = RX;
          end
        end else begin
          state_d = RX;
        end
      end
      DONE: begin
        if (frame_accept) begin
          rx_done_d = 1'b1;
          rx_byte_d = sreg_q[7:0];
        end else begin
          rx_done_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers for synchronisers, filter and receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta_q  <= 1'b0;
      c_sync_q  <= 1'b0;
      d_meta_q  <= 1'b0;
      d_sync_q  <= 1'b0;
      filt_q    <= '0;
      fclk_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sreg_q    <= 10'd0;
      rx_done_q <= 1'b0;
      rx_byte_q <= 8'd0;
    end else begin
      c_meta_q  <= ps2c;
      c_sync_q  <= c_meta_q;
      d_meta_q  <= ps2d;
      d_sync_q  <= d_meta_q;
      filt_q    <= filt_d;
      fclk_q    <= fclk_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      rx_done_q <= rx_done_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign rx_done = rx_done_q;
  assign rx_byte = rx_byte_q;

endmodule

// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard port: latches the released-key code and serves it over a port_id read mux.
// PS2_PARITY_CHECK_EN (optional define) is passed through to the receiver.
module ps2_keyboard_port
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0] DATA_PORT   = DATA_PORT_DEF,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF,
  parameter int         FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] dato
);

  logic       rx_done;
  logic [7:0] rx_byte;
  logic       break_pending_q, break_pending_d;
  logic [7:0] key_code_q, key_code_d;
  logic       valid_q, valid_d;
  logic [7:0] dato_q, dato_d;
  logic       key_set_s;
  logic       key_clr_s;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .clk    (clk),
    .rst_n  (reset),
    .ps2d   (ps2d),
    .ps2c   (ps2c),
    .rx_done(rx_done),
    .rx_byte(rx_byte)
  );

  // Only the byte after a break prefix is a key release; E0 leaves the prefix armed.
  always_comb begin
    break_pending_d = break_pending_q;
    key_code_d      = key_code_q;
    key_set_s       = 1'b0;
    if (rx_done) begin
      if (rx_byte == BREAK_CODE) begin
        break_pending_d = 1'b1;
      end else if (rx_byte == EXT_CODE) begin
        break_pending_d = break_pending_q;
      end else if (break_pending_q) begin
        key_code_d      = rx_byte;
        key_set_s       = 1'b1;
        break_pending_d = 1'b0;
      end else begin
        break_pending_d = break_pending_q;
      end
    end else begin
      break_pending_d = break_pending_q;
    end
  end

  // Valid flag: a newly landed code beats a simultaneous clearing read.
  always_comb begin
    key_clr_s = read_strobe && (port_id == DATA_PORT);
    if (key_set_s) begin
      valid_d = 1'b1;
    end else if (key_clr_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Read mux toward the processor.
  always_comb begin
    if (port_id == DATA_PORT) begin
      dato_d = key_code_q;
    end else if (port_id == STATUS_PORT) begin
      dato_d = {7'd0, valid_q};
    end else begin
      dato_d = 8'h00;
    end
  end

  // Decoder and read-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      break_pending_q <= 1'b0;
      key_code_q      <= 8'h00;
      valid_q         <= 1'b0;
      dato_q          <= 8'h00;
    end else begin
      break_pending_q <= break_pending_d;
      key_code_q      <= key_code_d;
      valid_q         <= valid_d;
      dato_q          <= dato_d;
    end
  end

  assign dato = dato_q;

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Directed bench for ps2_keyboard_port: scoreboard of expected dato values from a reference decoder model.
module tb_ps2_keyboard_port;

  localparam int         HP_CYC = 40;
  localparam logic [7:0] P_DATA = 8'h0A;
  localparam logic [7:0] P_STAT = 8'h0B;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] dato;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  logic [7:0] m_key;
  logic       m_valid;
  logic       m_bp;

  always #5ns clk = ~clk;

  ps2_keyboard_port dut (
    .clk        (clk),
    .reset      (reset),
    .ps2d       (ps2d),
    .ps2c       (ps2c),
    .port_id    (port_id),
    .read_strobe(read_strobe),
    .dato       (dato)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_key   = 8'h00;
    m_valid = 1'b0;
    m_bp    = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) begin
      m_bp = 1'b1;
    end else if (b == 8'hE0) begin
      m_bp = m_bp;
    end else if (m_bp) begin
      m_key   = b;
      m_valid = 1'b1;
      m_bp    = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_clk(HP_CYC / 2);
    ps2c = 1'b0;
    wait_clk(HP_CYC);
    ps2c = 1'b1;
    wait_clk(HP_CYC / 2);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
    end
    send_bit(~^b);
    send_bit(1'b1);
    ps2d = 1'b1;
    wait_clk(2 * HP_CYC);
    model_byte(b);
  endtask

  task automatic compare(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: scoreboard empty, dato=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: dato=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Processor read: expected value comes from the model before the read's side effect.
  task automatic do_read(input string tag, input logic [7:0] port, input logic strobe);
    logic [7:0] e;
    logic [7:0] obs;
    if (port == P_DATA) begin
      e = m_key;
    end else if (port == P_STAT) begin
      e = {7'd0, m_valid};
    end else begin
      e = 8'h00;
    end
    exp_q.push_back(e);
    if (strobe && port == P_DATA) m_valid = 1'b0;
    port_id     = port;
    read_strobe = strobe;
    @(negedge clk);
    obs = dato;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
    wait_clk(2);
    compare(tag, obs);
  endtask

  initial begin
    model_reset();
    reset       = 1'b0;
    ps2c        = 1'b0;
    ps2d        = 1'b0;
    port_id     = P_DATA;
    read_strobe = 1'b0;
    #100ns;
    @(negedge clk);
    exp_q.push_back(8'h00);
    compare("reset_dato", dato);
    reset = 1'b1;
    wait_clk(20);
    ps2c = 1'b1;
    ps2d = 1'b1;
    port_id = 8'h00;
    wait_clk(2 * HP_CYC);
    do_read("post_reset_status", P_STAT, 1'b0);
    do_read("post_reset_data", P_DATA, 1'b0);

    send_frame(8'hF0);
    send_frame(8'h1C);
    ps2d = 1'b1;
    wait_clk(HP_CYC / 2);
    ps2c = 1'b0;
    wait_clk(HP_CYC);
    ps2c = 1'b1;
    wait_clk(2 * HP_CYC);
    do_read("status_after_1c", P_STAT, 1'b0);
    do_read("read_1c", P_DATA, 1'b1);
    do_read("status_cleared", P_STAT, 1'b0);
    do_read("key_retained", P_DATA, 1'b0);
    do_read("unmapped_port", 8'h6A, 1'b0);

    send_frame(8'hF0);
    send_frame(8'h04);
    do_read("status_04", P_STAT, 1'b0);
    do_read("read_04", P_DATA, 1'b1);
    do_read("status_04_cleared", P_STAT, 1'b0);

    send_frame(8'h1C);
    do_read("make_ignored_status", P_STAT, 1'b0);
    do_read("make_ignored_key", P_DATA, 1'b0);

    send_frame(8'hF0);
    send_frame(8'hE0);
    send_frame(8'h75);
    do_read("status_75", P_STAT, 1'b0);
    do_read("read_75", P_DATA, 1'b1);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b0;
    wait_clk(10);
    model_reset();
    reset = 1'b1;
    ps2d  = 1'b1;
    wait_clk(2 * HP_CYC);
    do_read("midframe_reset_status", P_STAT, 1'b0);
    do_read("midframe_reset_key", P_DATA, 1'b0);

    send_frame(8'hF0);
    send_frame(8'h2A);
    do_read("status_2a", P_STAT, 1'b0);
    do_read("read_2a", P_DATA, 1'b1);
    do_read("status_2a_cleared", P_STAT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
